scr1_bpu_pred_tracker: RTL and testbench
========================================

Name: scr1_bpu_pred_tracker

Overview:
Tracks in-flight predictions from the IFU, which come from the branch predictor (BPU) lookup, until the EXU resolves the matching control-transfer instruction.
- Compares each resolved outcome with the stored prediction.
- Produces the registered BPU update bundle: b_type, pc_new_req, pc_prev, pc_new, prev_prediction, btb_miss.
- Raises a mispredict redirect to the pipeline.
- Sits between EXU resolution and the BPU update port. It is the direct upstream feeder of the BPU training inputs.

Parameters:
DEPTH, 4, number of in-flight prediction entries; must be a power of two, >= 2.
XLEN, `SCR1_XLEN, address width.

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
ifu2trk_push_i  in  1  IFU issues a control-transfer instruction with its prediction
ifu2trk_pc_i  in  XLEN  PC of that instruction
ifu2trk_rvi_i  in  1  1 = 32-bit instruction, 0 = 16-bit (RVC)
ifu2trk_pred_taken_i  in  1  predicted taken
ifu2trk_pred_pc_i  in  XLEN  predicted target
ifu2trk_btb_hit_i  in  1  BTB tag hit at lookup
trk2ifu_full_o  out  1  tracker full; IFU must stall control-transfer issue
exu2trk_res_vld_i  in  1  oldest tracked instruction resolved
exu2trk_b_type_i  in  1  resolved instruction is a conditional branch
exu2trk_taken_i  in  1  actual direction
exu2trk_target_i  in  XLEN  actual target
pipe2trk_flush_i  in  1  external flush (exception/trap/fence.i)
trk2bpu_b_type_o  out  1  BPU update: branch type, valid-qualified
trk2bpu_pc_new_req_o  out  1  BPU update: resolved taken, valid-qualified
trk2bpu_pc_prev_o  out  XLEN  BPU update: branch PC
trk2bpu_pc_new_o  out  XLEN  BPU update: actual target
trk2bpu_prev_prediction_o  out  1  BPU update: stored prediction
trk2bpu_btb_miss_o  out  1  BPU update: taken but BTB missed at lookup
trk2pipe_flush_o  out  1  mispredict redirect, one-cycle pulse
trk2pipe_flush_pc_o  out  XLEN  redirect PC
trk_underflow_o  out  1  resolution arrived with tracker empty, one-cycle pulse

Behaviour:
- Storage and pointers:
  - Circular FIFO of DEPTH entries {pc, rvi, pred_taken, pred_pc, btb_hit}.
  - wr_ptr and rd_ptr wrap modulo DEPTH; count spans 0..DEPTH.
  - trk2ifu_full_o = (count == DEPTH), combinational from registers.
- Reset: pointers and count = 0. All outputs 0; flush_pc_o = 0. Entry payload is not reset.
- Push: accepted when push_i && !full. Push while full is dropped; the IFU contract forbids it.
- Resolve: res_vld_i && count != 0 pops the head. res_vld_i with count == 0 is ignored and pulses trk_underflow_o next cycle.
- Mispredict for a popped head:
  - pred_taken != taken, or
  - taken && pred_pc != target.
- Fall-through PC = pc + (rvi ? 4 : 2), XLEN-bit wrap-around addition.
- Latency: all trk2bpu_* and trk2pipe_* outputs are registered and appear 1 cycle after the resolving cycle.
  - Update valid for exactly one cycle.
  - b_type_o = exu b_type.
  - pc_new_req_o = taken.
  - pc_prev_o = entry pc.
  - pc_new_o = target.
  - prev_prediction_o = pred_taken.
  - btb_miss_o = taken && !btb_hit.
  - When no update is valid, all 1-bit update outputs are 0 and the buses hold their last value.
- Mispredict handling:
  - trk2pipe_flush_o = 1 and flush_pc_o = (taken ? target : fall-through).
  - The whole FIFO is cleared in the same edge, since all younger entries are wrong-path.
  - A push in the same cycle is discarded.
- Simultaneous push and pop without mispredict: both happen, count unchanged. This is legal when full: the pop frees a slot and the push is accepted.
- pipe2trk_flush_i:
  - Highest priority; clears the FIFO.
  - Discards any same-cycle push and resolution: no BPU update, no redirect, no underflow pulse.
  - Outputs already registered from the previous cycle still appear.
- An entry pushed at cycle N is resolvable from cycle N+1; same-cycle push-and-resolve into an empty FIFO counts as underflow.

Decomposition:
- scr1_bpu_pkg holds the entry struct type_scr1_bpu_trk_entry_s {pc, rvi, pred_taken, pred_pc, btb_hit} and the fall-through length constants (4/2).
- One sub-module, scr1_bpu_trk_fifo: parameterised storage, pointers and count, plus push/pop/clear ports.
- The top level contains compare, priority and output registers.

Test Plan:
1. Push pc=0x200 rvi=1 pred_taken=1 pred_pc=0x300 btb_hit=1; resolve taken target=0x300 b_type=1 -> next cycle b_type=1, pc_new_req=1, prev_prediction=1, btb_miss=0, flush=0; count returns to 0.
2. Push pc=0x100 rvi=0 pred_taken=1 pred_pc=0x180; resolve not-taken -> flush=1, flush_pc=0x102, pc_new_req=0, prev_prediction=1.
3. Push pc=0x400 pred_taken=0 btb_hit=0, then push 3 more; resolve head taken target=0x480 -> btb_miss=1, flush_pc=0x480, count=0; a push in the resolving cycle is dropped.
4. Fill DEPTH=4 -> full=1; push+resolve (correct) same cycle -> push accepted, count stays 4; pointers wrap correctly over 3 full cycles.
5. Resolve with empty FIFO -> underflow pulse, no BPU update; pipe2trk_flush_i together with resolve of a mispredict -> no update, no redirect, count=0.
6. Reset asserted mid-stream with 3 entries -> full=0, all outputs 0 asynchronously; first push after release is stored at slot 0.

Source files
------------

// File: rtl/scr1_bpu_pkg.sv
// Shared types for the BPU prediction tracker: tracked entry layout and fall-through sizes.
`ifndef SCR1_XLEN
`define SCR1_XLEN 32
`endif

package scr1_bpu_pkg;

  localparam int unsigned SCR1_BPU_XLEN = `SCR1_XLEN;

  localparam logic [2:0] SCR1_BPU_FT_RVI = 3'd4;
  localparam logic [2:0] SCR1_BPU_FT_RVC = 3'd2;

  typedef struct packed {
    logic [SCR1_BPU_XLEN-1:0] pc;
    logic                     rvi;
    logic                     pred_taken;
    logic [SCR1_BPU_XLEN-1:0] pred_pc;
    logic                     btb_hit;
  } type_scr1_bpu_trk_entry_s;

endpackage

// File: rtl/scr1_bpu_trk_fifo.sv
// Circular store of in-flight predictions; head visible combinationally, updates on the clock.
// Clear beats push/pop; the caller gates pushes so none lands while full without a pop.
module scr1_bpu_trk_fifo
  import scr1_bpu_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  type_scr1_bpu_trk_entry_s push_dat_i,
  input  logic                     pop_i,
  input  logic                     clr_i,
  output type_scr1_bpu_trk_entry_s head_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  type_scr1_bpu_trk_entry_s mem_q [DEPTH];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + {{PW{1'b0}}, push_i} - {{PW{1'b0}}, pop_i};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (push_i && !clr_i) mem_q[wr_ptr_q] <= push_dat_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/scr1_bpu_pred_tracker.sv
// Matches EXU resolutions against stored IFU predictions; BPU update and redirect 1 cycle later.
// IFU stalls on trk2ifu_full_o (a same-cycle pop frees a slot); flush and mispredict clear all entries.
module scr1_bpu_pred_tracker
  import scr1_bpu_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned XLEN  = `SCR1_XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ifu2trk_push_i,
  input  logic [XLEN-1:0] ifu2trk_pc_i,
  input  logic            ifu2trk_rvi_i,
  input  logic            ifu2trk_pred_taken_i,
  input  logic [XLEN-1:0] ifu2trk_pred_pc_i,
  input  logic            ifu2trk_btb_hit_i,
  output logic            trk2ifu_full_o,
  input  logic            exu2trk_res_vld_i,
  input  logic            exu2trk_b_type_i,
  input  logic            exu2trk_taken_i,
  input  logic [XLEN-1:0] exu2trk_target_i,
  input  logic            pipe2trk_flush_i,
  output logic            trk2bpu_b_type_o,
  output logic            trk2bpu_pc_new_req_o,
  output logic [XLEN-1:0] trk2bpu_pc_prev_o,
  output logic [XLEN-1:0] trk2bpu_pc_new_o,
  output logic            trk2bpu_prev_prediction_o,
  output logic            trk2bpu_btb_miss_o,
  output logic            trk2pipe_flush_o,
  output logic [XLEN-1:0] trk2pipe_flush_pc_o,
  output logic            trk_underflow_o
);

  type_scr1_bpu_trk_entry_s push_dat;
  type_scr1_bpu_trk_entry_s head;
  logic full, empty, pop, mispred, clr, push_ok;
  logic [XLEN-1:0] ft_pc;

  logic            b_type_q, b_type_d;
  logic            pc_new_req_q, pc_new_req_d;
  logic [XLEN-1:0] pc_prev_q, pc_prev_d;
  logic [XLEN-1:0] pc_new_q, pc_new_d;
  logic            prev_pred_q, prev_pred_d;
  logic            btb_miss_q, btb_miss_d;
  logic            flush_q, flush_d;
  logic [XLEN-1:0] flush_pc_q, flush_pc_d;
  logic            underflow_q, underflow_d;

  assign push_dat = '{pc:         ifu2trk_pc_i,
                      rvi:        ifu2trk_rvi_i,
                      pred_taken: ifu2trk_pred_taken_i,
                      pred_pc:    ifu2trk_pred_pc_i,
                      btb_hit:    ifu2trk_btb_hit_i};

  // External flush outranks everything, including a resolution in the same cycle.
  assign pop     = exu2trk_res_vld_i && !empty && !pipe2trk_flush_i;
  assign mispred = (head.pred_taken != exu2trk_taken_i)
                || (exu2trk_taken_i && (head.pred_pc != exu2trk_target_i));
  assign clr     = pipe2trk_flush_i || (pop && mispred);
  assign push_ok = ifu2trk_push_i && (!full || pop) && !clr;
  assign ft_pc   = head.pc + XLEN'(head.rvi ? SCR1_BPU_FT_RVI : SCR1_BPU_FT_RVC);

  scr1_bpu_trk_fifo #(.DEPTH(DEPTH)) i_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (push_ok),
    .push_dat_i (push_dat),
    .pop_i      (pop),
    .clr_i      (clr),
    .head_o     (head),
    .full_o     (full),
    .empty_o    (empty)
  );

  always_comb begin
    b_type_d     = pop && exu2trk_b_type_i;
    pc_new_req_d = pop && exu2trk_taken_i;
    prev_pred_d  = pop && head.pred_taken;
    btb_miss_d   = pop && exu2trk_taken_i && !head.btb_hit;
    flush_d      = pop && mispred;
    underflow_d  = exu2trk_res_vld_i && empty && !pipe2trk_flush_i;
    pc_prev_d    = pc_prev_q;
    pc_new_d     = pc_new_q;
    flush_pc_d   = flush_pc_q;
    if (pop) begin
      pc_prev_d = head.pc;
      pc_new_d  = exu2trk_target_i;
    end
    if (pop && mispred) flush_pc_d = exu2trk_taken_i ? exu2trk_target_i : ft_pc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_type_q     <= 1'b0;
      pc_new_req_q <= 1'b0;
      pc_prev_q    <= '0;
      pc_new_q     <= '0;
      prev_pred_q  <= 1'b0;
      btb_miss_q   <= 1'b0;
      flush_q      <= 1'b0;
      flush_pc_q   <= '0;
      underflow_q  <= 1'b0;
    end else begin
      b_type_q     <= b_type_d;
      pc_new_req_q <= pc_new_req_d;
      pc_prev_q    <= pc_prev_d;
      pc_new_q     <= pc_new_d;
      prev_pred_q  <= prev_pred_d;
      btb_miss_q   <= btb_miss_d;
      flush_q      <= flush_d;
      flush_pc_q   <= flush_pc_d;
      underflow_q  <= underflow_d;
    end
  end

  assign trk2ifu_full_o            = full;
  assign trk2bpu_b_type_o          = b_type_q;
  assign trk2bpu_pc_new_req_o      = pc_new_req_q;
  assign trk2bpu_pc_prev_o         = pc_prev_q;
  assign trk2bpu_pc_new_o          = pc_new_q;
  assign trk2bpu_prev_prediction_o = prev_pred_q;
  assign trk2bpu_btb_miss_o        = btb_miss_q;
  assign trk2pipe_flush_o          = flush_q;
  assign trk2pipe_flush_pc_o       = flush_pc_q;
  assign trk_underflow_o           = underflow_q;

endmodule

// File: tb/tb_scr1_bpu_pred_tracker.sv
// Directed bench for scr1_bpu_pred_tracker: queue-based reference model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_scr1_bpu_pred_tracker;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        push = 1'b0, rvi = 1'b0, pt = 1'b0, hit = 1'b0;
  logic [31:0] pc = '0, ppc = '0, tgt = '0;
  logic        res = 1'b0, bt = 1'b0, tk = 1'b0, fl_in = 1'b0;

  logic        full, o_bt, o_req, o_prev, o_miss, o_fl, o_under;
  logic [31:0] o_pc_prev, o_pc_new, o_fpc;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  scr1_bpu_pred_tracker #(.DEPTH(DEPTH), .XLEN(32)) dut (
    .clk                       (clk),
    .rst_n                     (rst_n),
    .ifu2trk_push_i            (push),
    .ifu2trk_pc_i              (pc),
    .ifu2trk_rvi_i             (rvi),
    .ifu2trk_pred_taken_i      (pt),
    .ifu2trk_pred_pc_i         (ppc),
    .ifu2trk_btb_hit_i         (hit),
    .trk2ifu_full_o            (full),
    .exu2trk_res_vld_i         (res),
    .exu2trk_b_type_i          (bt),
    .exu2trk_taken_i           (tk),
    .exu2trk_target_i          (tgt),
    .pipe2trk_flush_i          (fl_in),
    .trk2bpu_b_type_o          (o_bt),
    .trk2bpu_pc_new_req_o      (o_req),
    .trk2bpu_pc_prev_o         (o_pc_prev),
    .trk2bpu_pc_new_o          (o_pc_new),
    .trk2bpu_prev_prediction_o (o_prev),
    .trk2bpu_btb_miss_o        (o_miss),
    .trk2pipe_flush_o          (o_fl),
    .trk2pipe_flush_pc_o       (o_fpc),
    .trk_underflow_o           (o_under)
  );

  typedef struct {
    logic [31:0] pc;
    bit          rvi;
    bit          pt;
    logic [31:0] ppc;
    bit          hit;
  } m_ent_t;

  m_ent_t      mq[$];
  bit          e_bt, e_req, e_prev, e_miss, e_fl, e_under;
  logic [31:0] e_pc_prev, e_pc_new, e_fpc;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: in-flight predictions as a queue, outputs computed from the rules.
  initial begin
    e_bt = 0; e_req = 0; e_prev = 0; e_miss = 0; e_fl = 0; e_under = 0;
    e_pc_prev = '0; e_pc_new = '0; e_fpc = '0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        mq.delete();
        e_bt = 0; e_req = 0; e_prev = 0; e_miss = 0; e_fl = 0; e_under = 0;
        e_pc_prev = '0; e_pc_new = '0; e_fpc = '0;
      end else begin
        automatic int     n   = mq.size();
        automatic bit     pop = 0;
        automatic bit     mis = 0;
        automatic m_ent_t h;
        e_bt = 0; e_req = 0; e_prev = 0; e_miss = 0; e_fl = 0; e_under = 0;
        if (fl_in) begin
          mq.delete();
        end else begin
          if (res && n == 0) e_under = 1;
          if (res && n != 0) begin
            h = mq.pop_front();
            pop = 1;
            e_bt = bt; e_req = tk; e_prev = h.pt; e_miss = tk && !h.hit;
            e_pc_prev = h.pc; e_pc_new = tgt;
            mis = (h.pt != tk) || (tk && h.ppc != tgt);
            if (mis) begin
              e_fl = 1;
              e_fpc = tk ? tgt : h.pc + (h.rvi ? 32'd4 : 32'd2);
              mq.delete();
            end
          end
          if (push && !mis && (n < DEPTH || pop))
            mq.push_back('{pc: pc, rvi: rvi, pt: pt, ppc: ppc, hit: hit});
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("full",      full,      (mq.size() == DEPTH) ? 32'd1 : 32'd0);
      chk("b_type",    o_bt,      e_bt);
      chk("pc_new_req", o_req,    e_req);
      chk("prev_pred", o_prev,    e_prev);
      chk("btb_miss",  o_miss,    e_miss);
      chk("flush",     o_fl,      e_fl);
      chk("underflow", o_under,   e_under);
      chk("pc_prev",   o_pc_prev, e_pc_prev);
      chk("pc_new",    o_pc_new,  e_pc_new);
      chk("flush_pc",  o_fpc,     e_fpc);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    push = 0; rvi = 0; pt = 0; ppc = '0; hit = 0; pc = '0;
    res = 0; bt = 0; tk = 0; tgt = '0; fl_in = 0;
  endtask

  task automatic set_push(input logic [31:0] a, input bit r, input bit p,
                          input logic [31:0] b, input bit h);
    push = 1; pc = a; rvi = r; pt = p; ppc = b; hit = h;
  endtask

  task automatic set_res(input bit b, input bit t, input logic [31:0] g);
    res = 1; bt = b; tk = t; tgt = g;
  endtask

  task automatic do_push(input logic [31:0] a, input bit r, input bit p,
                         input logic [31:0] b, input bit h);
    idle(); set_push(a, r, p, b, h); tick();
  endtask

  task automatic do_res(input bit b, input bit t, input logic [31:0] g);
    idle(); set_res(b, t, g); tick();
  endtask

  initial begin
    #1 rst_n = 0;
    tick(); tick();
    rst_n = 1;
    chk("rst_full", full, 0);
    chk("rst_flush_pc", o_fpc, 0);

    // 1: correctly predicted taken branch
    do_push(32'h200, 1, 1, 32'h300, 1);
    do_res(1, 1, 32'h300);
    chk("t1_b_type", o_bt, 1);
    chk("t1_req", o_req, 1);
    chk("t1_prev", o_prev, 1);
    chk("t1_miss", o_miss, 0);
    chk("t1_flush", o_fl, 0);
    chk("t1_pc_prev", o_pc_prev, 32'h200);
    idle(); tick();
    chk("t1_pulse", o_bt, 0);

    // 2: RVC predicted taken, actually not taken
    do_push(32'h100, 0, 1, 32'h180, 1);
    do_res(1, 0, 32'h104);
    chk("t2_flush", o_fl, 1);
    chk("t2_flush_pc", o_fpc, 32'h102);
    chk("t2_req", o_req, 0);
    chk("t2_prev", o_prev, 1);
    idle(); tick();
    chk("t2_pulse", o_fl, 0);

    // 3: head mispredicts with BTB miss; younger entries and same-cycle push dropped
    do_push(32'h400, 1, 0, 32'h0, 0);
    do_push(32'h404, 1, 0, 32'h0, 1);
    do_push(32'h408, 1, 0, 32'h0, 1);
    do_push(32'h40c, 1, 0, 32'h0, 1);
    idle(); set_res(1, 1, 32'h480); set_push(32'h500, 1, 0, 32'h0, 1); tick();
    chk("t3_miss", o_miss, 1);
    chk("t3_flush", o_fl, 1);
    chk("t3_flush_pc", o_fpc, 32'h480);
    chk("t3_full", full, 0);
    do_res(1, 0, 32'h0);
    chk("t3_empty_after", o_under, 1);

    // 4: full, then push+pop in the same cycle while full
    for (int i = 0; i < 4; i++) do_push(32'h600 + 32'(4 * i), 1, 0, 32'h0, 1);
    chk("t4_full", full, 1);
    for (int i = 0; i < 3; i++) begin
      idle(); set_res(1, 0, 32'h0); set_push(32'h700 + 32'(4 * i), 1, 0, 32'h0, 1); tick();
      chk("t4_pp_pc_prev", o_pc_prev, 32'h600 + 32'(4 * i));
      chk("t4_pp_full", full, 1);
      chk("t4_pp_flush", o_fl, 0);
    end
    do_res(1, 0, 32'h0); chk("t4_d0", o_pc_prev, 32'h60c);
    do_res(1, 0, 32'h0); chk("t4_d1", o_pc_prev, 32'h700);
    do_res(1, 0, 32'h0); chk("t4_d2", o_pc_prev, 32'h704);
    do_res(1, 0, 32'h0); chk("t4_d3", o_pc_prev, 32'h708);
    chk("t4_drained", full, 0);

    // 5: underflow, then external flush against a mispredicting resolve
    do_res(1, 0, 32'h0);
    chk("t5_under", o_under, 1);
    chk("t5_no_upd", o_bt, 0);
    do_push(32'h800, 1, 1, 32'h900, 1);
    idle(); set_res(1, 0, 32'h0); fl_in = 1; tick();
    chk("t5_fl_noredir", o_fl, 0);
    chk("t5_fl_noupd", o_bt, 0);
    chk("t5_fl_nounder", o_under, 0);
    chk("t5_fl_pc_hold", o_fpc, 32'h480);
    do_res(1, 0, 32'h0);
    chk("t5_cleared", o_under, 1);

    // 6: asynchronous reset with entries in flight
    do_push(32'hb00, 1, 0, 32'h0, 1);
    do_push(32'hb04, 1, 0, 32'h0, 1);
    do_push(32'hb08, 1, 0, 32'h0, 1);
    idle();
    #2 rst_n = 0;
    #1;
    chk("t6_full", full, 0);
    chk("t6_pc_prev", o_pc_prev, 0);
    chk("t6_flush_pc", o_fpc, 0);
    chk("t6_under", o_under, 0);
    tick();
    rst_n = 1;
    do_push(32'ha00, 0, 1, 32'ha80, 1);
    do_res(0, 1, 32'ha80);
    chk("t6_pc_prev_after", o_pc_prev, 32'ha00);
    chk("t6_pc_new_after", o_pc_new, 32'ha80);
    chk("t6_flush_after", o_fl, 0);
    chk("t6_req_after", o_req, 1);

    idle(); tick(); tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
